// File: rtl/pipe_stall_ctrl.sv
// Central hazard/stall controller for the 5-stage core: merges bus waits,
// load-use, multi-cycle divide timing and precise exception flush.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_busy,
  input  logic       d_busy,
  input  logic       load_use,
  input  logic       div_req,
  input  logic       exc_req,
  output logic [5:0] stall,
  output logic       flush,
  output logic       div_start,
  output logic       div_done
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    DIV_DONE,
    FLUSH_PEND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic       flush_c;
  logic       div_stall;
  logic       start_c;
  logic [5:0] stall_c;

  always_comb begin
    flush_c   = (state == FLUSH_PEND) ? !d_busy : (exc_req && !d_busy);
    div_stall = (state == IDLE && div_req) || (state == DIV_RUN);
    start_c   = (state == IDLE) && div_req && !exc_req;
    stall_c   = '0;
    // Patterns are prefixes of one another, so OR-ing keeps the longest.
    if (i_busy)    stall_c = stall_c | 6'b000011;
    if (load_use)  stall_c = stall_c | 6'b000111;
    if (div_stall) stall_c = stall_c | 6'b001111;
    if (d_busy)    stall_c = stall_c | 6'b011111;
    if (flush_c)   stall_c = '0;
  end

  // Reset gates every output, including the combinational ones.
  assign stall     = rst ? stall_c : '0;
  assign flush     = rst && flush_c;
  assign div_start = rst && start_c && !flush_c;
  assign div_done  = rst && (state == DIV_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush_c) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (exc_req && d_busy && state != FLUSH_PEND) begin
      state <= FLUSH_PEND;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_req) begin
            state <= DIV_RUN;
            cnt   <= CNT_W'(DIV_CYCLES - 1);
          end
        end
        DIV_RUN: begin
          if (cnt == CNT_W'(1)) begin
            state <= DIV_DONE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIV_DONE: begin
          if (!d_busy) state <= IDLE;
        end
        FLUSH_PEND: begin
          state <= FLUSH_PEND;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed and randomized checks of pipe_stall_ctrl against a cycle-count
// reference model of hazard merging, divide timing and exception flush.
module tb_pipe_stall_ctrl;

  localparam int DIVC = 34;

  logic       clk;
  logic       rst;
  logic       i_busy, d_busy, load_use, div_req, exc_req;
  logic [5:0] stall;
  logic       flush, div_start, div_done;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining divide-stall cycles, result-ready flag,
  // and an exception waiting for the data bus.
  int div_left = 0;
  bit ready    = 0;
  bit pend     = 0;

  // Observation tallies for the directed scenarios.
  int starts, dones, stall3s, flushes;

  pipe_stall_ctrl #(.DIV_CYCLES(DIVC)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (i_busy),
    .d_busy   (d_busy),
    .load_use (load_use),
    .div_req  (div_req),
    .exc_req  (exc_req),
    .stall    (stall),
    .flush    (flush),
    .div_start(div_start),
    .div_done (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    starts = 0; dones = 0; stall3s = 0; flushes = 0;
  endtask

  task automatic step(input logic r, input logic ib, input logic db,
                      input logic lu, input logic dr, input logic er);
    bit         idle, dstall, e_flush, e_start, e_done;
    int         lvl;
    logic [5:0] e_stall;
    rst = r; i_busy = ib; d_busy = db; load_use = lu; div_req = dr; exc_req = er;
    #3;
    idle    = !pend && !ready && (div_left == 0);
    e_flush = r && (pend ? !db : (er && !db));
    dstall  = (div_left > 0) || (idle && dr);
    e_start = r && idle && dr && !er;
    e_done  = r && ready;
    lvl = 0;
    if (ib)     lvl = 2;
    if (lu)     lvl = 3;
    if (dstall) lvl = 4;
    if (db)     lvl = 5;
    e_stall = 6'((1 << lvl) - 1);
    if (!r || e_flush) e_stall = '0;
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("div_start", 32'(div_start), 32'(e_start));
    chk("div_done", 32'(div_done), 32'(e_done));
    if (div_start) starts++;
    if (div_done)  dones++;
    if (stall[3])  stall3s++;
    if (flush)     flushes++;
    if (!r || e_flush) begin
      div_left = 0; ready = 0; pend = 0;
    end else if (er && db && !pend) begin
      pend = 1; div_left = 0; ready = 0;
    end else if (idle && dr) begin
      div_left = DIVC - 1;
    end else if (div_left > 0) begin
      div_left--;
      if (div_left == 0) ready = 1;
    end else if (ready && !db) begin
      ready = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; i_busy = 0; d_busy = 0; load_use = 0; div_req = 0; exc_req = 0;
    @(posedge clk);
    #1;

    // Reset with every input high: all outputs held low.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 1);
    step(1, 0, 0, 0, 0, 0);

    // Single hazards and combinations.
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Full divide: one start, 34 stall cycles, result then consumed.
    clr_tally();
    for (int i = 0; i < DIVC + 1; i++) step(1, (i % 7) == 3, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("div3_starts", 32'(starts), 32'd1);
    chk("div3_stall3", 32'(stall3s), 32'(DIVC));
    chk("div3_dones", 32'(dones), 32'd1);

    // Exception mid-divide with free data bus: immediate flush, no result.
    clr_tally();
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("exc4_flushes", 32'(flushes), 32'd1);
    chk("exc4_dones", 32'(dones), 32'd0);

    // Exception waiting on data bus for 5 cycles, then flush.
    clr_tally();
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("exc5_flushes", 32'(flushes), 32'd1);

    // Divide completing under a data-bus wait: result held 4 cycles.
    clr_tally();
    for (int i = 0; i < DIVC + 4; i++) step(1, 0, (i >= DIVC) && (i < DIVC + 3), 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("div6_starts", 32'(starts), 32'd1);
    chk("div6_dones", 32'(dones), 32'd4);

    // Reset mid-divide and mid-pending-flush.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
